// File: rtl/entrada_teclado.sv
// Keypad front-end for the ATM controller: forwards PIN digits as strobes and
// accumulates decimal amount keys into a confirmed 32-bit binary amount.
module entrada_teclado #(
    parameter int unsigned PIN_DIGITS     = 4,
    parameter int unsigned MAX_DIGITS     = 9,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  tecla,
    input  logic        tecla_valida,
    input  logic        pedir_pin,
    input  logic        pedir_monto,
    output logic [4:0]  digito,
    output logic        digito_stb,
    output logic [31:0] monto,
    output logic        monto_stb,
    output logic        cancelar,
    output logic        tiempo_agotado,
    output logic        error_monto,
    output logic        ocupado
);

    localparam int unsigned CW = $clog2(PIN_DIGITS + MAX_DIGITS + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        REPOSO = 2'd0,
        PIN    = 2'd1,
        MONTO  = 2'd2
    } state_t;

    state_t        state, state_next;
    logic [31:0]   acc, acc_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [TW-1:0] tmo, tmo_d;

    logic [4:0]    digito_d;
    logic [31:0]   monto_d;
    logic          digito_stb_d, monto_stb_d, cancelar_d, tiempo_agotado_d;
    logic          error_monto_d, ocupado_d;

    logic          en_entrada, tecla_ok, es_digito, fin_tiempo, desborde;
    logic [35:0]   nuevo;

    // Codes 13-15 are invisible to the block, including the idle counter.
    assign en_entrada = (state == PIN) || (state == MONTO);
    assign tecla_ok   = tecla_valida && (tecla <= 4'd12);
    assign es_digito  = tecla <= 4'd9;
    assign fin_tiempo = tmo == TW'(TIMEOUT_CYCLES - 1);
    assign nuevo      = 36'(acc) * 36'd10 + 36'(tecla);
    assign desborde   = nuevo[35:32] != 4'd0;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= REPOSO;
        else        state <= state_next;
    end

    // Next state: requests first, then a valid key, then the idle timeout
    always_comb begin
        state_next = state;
        if (pedir_pin) begin
            state_next = PIN;
        end else if (pedir_monto) begin
            state_next = MONTO;
        end else if (en_entrada && tecla_ok) begin
            if (tecla == 4'd12) begin
                state_next = REPOSO;
            end else if (state == PIN) begin
                if (es_digito && cnt == CW'(PIN_DIGITS - 1)) state_next = REPOSO;
            end else if (tecla == 4'd11 && cnt != '0) begin
                state_next = REPOSO;
            end
        end else if (en_entrada && fin_tiempo) begin
            state_next = REPOSO;
        end else if (!en_entrada) begin
            state_next = REPOSO;
        end
    end

    // Datapath and next output values
    always_comb begin
        acc_d            = acc;
        cnt_d            = cnt;
        tmo_d            = en_entrada ? tmo + TW'(1) : '0;
        digito_d         = digito;
        monto_d          = monto;
        digito_stb_d     = 1'b0;
        monto_stb_d      = 1'b0;
        cancelar_d       = 1'b0;
        tiempo_agotado_d = 1'b0;
        error_monto_d    = error_monto;
        ocupado_d        = state_next != REPOSO;

        if (pedir_pin) begin
            cnt_d = '0;
            tmo_d = '0;
        end else if (pedir_monto) begin
            acc_d         = '0;
            cnt_d         = '0;
            tmo_d         = '0;
            error_monto_d = 1'b0;
        end else if (en_entrada && tecla_ok) begin
            tmo_d = '0;
            if (tecla == 4'd12) begin
                cancelar_d = 1'b1;
            end else if (state == PIN) begin
                if (es_digito) begin
                    digito_d     = {1'b0, tecla};
                    digito_stb_d = 1'b1;
                    cnt_d        = cnt + CW'(1);
                end
            end else if (es_digito) begin
                // Overflow flags an error; a full digit count silently drops the key.
                if (desborde) begin
                    error_monto_d = 1'b1;
                end else if (cnt != CW'(MAX_DIGITS)) begin
                    acc_d = nuevo[31:0];
                    cnt_d = cnt + CW'(1);
                end
            end else if (tecla == 4'd10) begin
                acc_d = '0;
                cnt_d = '0;
            end else if (cnt != '0) begin
                monto_d     = acc;
                monto_stb_d = 1'b1;
            end
        end else if (en_entrada && fin_tiempo) begin
            tiempo_agotado_d = 1'b1;
            tmo_d            = '0;
        end
    end

    // Registered datapath and outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc            <= '0;
            cnt            <= '0;
            tmo            <= '0;
            digito         <= '0;
            monto          <= '0;
            digito_stb     <= 1'b0;
            monto_stb      <= 1'b0;
            cancelar       <= 1'b0;
            tiempo_agotado <= 1'b0;
            error_monto    <= 1'b0;
            ocupado        <= 1'b0;
        end else begin
            acc            <= acc_d;
            cnt            <= cnt_d;
            tmo            <= tmo_d;
            digito         <= digito_d;
            monto          <= monto_d;
            digito_stb     <= digito_stb_d;
            monto_stb      <= monto_stb_d;
            cancelar       <= cancelar_d;
            tiempo_agotado <= tiempo_agotado_d;
            error_monto    <= error_monto_d;
            ocupado        <= ocupado_d;
        end
    end

endmodule

// File: tb/tb_entrada_teclado.sv
// Bench for entrada_teclado: two instances (9- and 10-digit amount limits) run
// against a transaction-level model of the keypad rules.
module tb_entrada_teclado;

    localparam int T   = 8;
    localparam int PIN_N = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] tecla;
    logic       tecla_valida, pedir_pin, pedir_monto;

    logic [4:0]  digito [2];
    logic [31:0] monto [2];
    logic        digito_stb [2], monto_stb [2], cancelar [2];
    logic        tiempo_agotado [2], error_monto [2], ocupado [2];

    entrada_teclado #(.PIN_DIGITS(PIN_N), .MAX_DIGITS(9), .TIMEOUT_CYCLES(T)) u_a (
        .clk(clk), .reset(reset), .tecla(tecla), .tecla_valida(tecla_valida),
        .pedir_pin(pedir_pin), .pedir_monto(pedir_monto),
        .digito(digito[0]), .digito_stb(digito_stb[0]), .monto(monto[0]),
        .monto_stb(monto_stb[0]), .cancelar(cancelar[0]),
        .tiempo_agotado(tiempo_agotado[0]), .error_monto(error_monto[0]),
        .ocupado(ocupado[0]));

    entrada_teclado #(.PIN_DIGITS(PIN_N), .MAX_DIGITS(10), .TIMEOUT_CYCLES(T)) u_b (
        .clk(clk), .reset(reset), .tecla(tecla), .tecla_valida(tecla_valida),
        .pedir_pin(pedir_pin), .pedir_monto(pedir_monto),
        .digito(digito[1]), .digito_stb(digito_stb[1]), .monto(monto[1]),
        .monto_stb(monto_stb[1]), .cancelar(cancelar[1]),
        .tiempo_agotado(tiempo_agotado[1]), .error_monto(error_monto[1]),
        .ocupado(ocupado[1]));

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model: mode 0 idle, 1 PIN entry, 2 amount entry
    int          max_d [2] = '{9, 10};
    int          m_mode [2];
    longint      m_acc [2];
    int          m_cnt [2];
    int          m_last [2];
    bit          m_err [2];
    int          m_dig [2];
    longint      m_mon [2];
    bit          e_dstb [2], e_mstb [2], e_can [2], e_to [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = 0; m_acc[i] = 0; m_cnt[i] = 0; m_last[i] = 0;
            m_err[i] = 0; m_dig[i] = 0; m_mon[i] = 0;
            e_dstb[i] = 0; e_mstb[i] = 0; e_can[i] = 0; e_to[i] = 0;
        end
    endtask

    task automatic model_edge();
        int k;
        bit key;
        longint nv;
        k   = int'(tecla);
        key = tecla_valida && k <= 12;
        for (int i = 0; i < 2; i++) begin
            e_dstb[i] = 0; e_mstb[i] = 0; e_can[i] = 0; e_to[i] = 0;
            if (pedir_pin) begin
                m_mode[i] = 1; m_cnt[i] = 0; m_last[i] = cyc;
            end else if (pedir_monto) begin
                m_mode[i] = 2; m_cnt[i] = 0; m_acc[i] = 0; m_err[i] = 0; m_last[i] = cyc;
            end else if (m_mode[i] != 0 && key) begin
                m_last[i] = cyc;
                if (k == 12) begin
                    e_can[i] = 1; m_mode[i] = 0;
                end else if (m_mode[i] == 1) begin
                    if (k <= 9) begin
                        m_dig[i] = k; e_dstb[i] = 1; m_cnt[i]++;
                        if (m_cnt[i] == PIN_N) m_mode[i] = 0;
                    end
                end else if (k <= 9) begin
                    nv = m_acc[i] * 10 + longint'(k);
                    if (nv > 64'hFFFF_FFFF) m_err[i] = 1;
                    else if (m_cnt[i] < max_d[i]) begin
                        m_acc[i] = nv; m_cnt[i]++;
                    end
                end else if (k == 10) begin
                    m_acc[i] = 0; m_cnt[i] = 0;
                end else if (m_cnt[i] > 0) begin
                    m_mon[i] = m_acc[i]; e_mstb[i] = 1; m_mode[i] = 0;
                end
            end else if (m_mode[i] != 0 && cyc - m_last[i] == T) begin
                e_to[i] = 1; m_mode[i] = 0;
            end
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("digito%0d", i),     32'(digito[i]),         32'(m_dig[i]));
            chk($sformatf("digito_stb%0d", i), 32'(digito_stb[i]),     32'(e_dstb[i]));
            chk($sformatf("monto%0d", i),      monto[i],               32'(m_mon[i]));
            chk($sformatf("monto_stb%0d", i),  32'(monto_stb[i]),      32'(e_mstb[i]));
            chk($sformatf("cancelar%0d", i),   32'(cancelar[i]),       32'(e_can[i]));
            chk($sformatf("tiempo%0d", i),     32'(tiempo_agotado[i]), 32'(e_to[i]));
            chk($sformatf("error_monto%0d", i), 32'(error_monto[i]),   32'(m_err[i]));
            chk($sformatf("ocupado%0d", i),    32'(ocupado[i]),        32'(m_mode[i] != 0));
        end
    endtask

    task automatic step(input bit tv, input logic [3:0] k, input bit pp, input bit pm);
        tecla_valida = tv; tecla = k; pedir_pin = pp; pedir_monto = pm;
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        compare_all();
        tecla_valida = 1'b0; pedir_pin = 1'b0; pedir_monto = 1'b0;
    endtask

    task automatic key(input logic [3:0] k);
        step(1'b1, k, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic keys_num(input string s);
        for (int i = 0; i < s.len(); i++) key(4'(s[i] - 8'd48));
    endtask

    initial begin
        reset = 1'b0; tecla = '0; tecla_valida = 1'b0; pedir_pin = 1'b0; pedir_monto = 1'b0;
        model_reset();
        #12;
        compare_all();
        @(negedge clk);
        reset = 1'b1;

        // PIN entry, exactly four digits forwarded
        step(1'b0, 4'd0, 1'b1, 1'b0);
        for (int d = 1; d <= 4; d++) begin
            key(4'(d));
            chk("pin_digito", 32'(digito[0]), 32'(d));
            chk("pin_stb", 32'(digito_stb[0]), 32'd1);
        end
        chk("pin_ocupado_low", 32'(ocupado[0]), 32'd0);
        key(4'd5);
        chk("pin_5th_no_stb", 32'(digito_stb[0]), 32'd0);

        // Amount 2500, then BORRAR recovery
        step(1'b0, 4'd0, 1'b0, 1'b1);
        keys_num("2500");
        key(4'd11);
        chk("monto_2500", monto[0], 32'd2500);
        chk("monto_2500_stb", 32'(monto_stb[0]), 32'd1);
        idle(1);
        chk("monto_stb_once", 32'(monto_stb[0]), 32'd0);
        step(1'b0, 4'd0, 1'b0, 1'b1);
        keys_num("25");
        key(4'd10);
        key(4'd7);
        key(4'd11);
        chk("monto_7", monto[0], 32'd7);

        // Digit limit and overflow
        step(1'b0, 4'd0, 1'b0, 1'b1);
        keys_num("4294967295");
        key(4'd11);
        chk("monto_9dig", monto[0], 32'd429496729);
        chk("err_9dig", 32'(error_monto[0]), 32'd0);
        step(1'b0, 4'd0, 1'b0, 1'b1);
        keys_num("4294967296");
        chk("err_overflow", 32'(error_monto[1]), 32'd1);
        key(4'd11);
        chk("monto_overflow", monto[1], 32'd429496729);

        // Cancel and empty ENTER
        step(1'b0, 4'd0, 1'b1, 1'b0);
        key(4'd3);
        key(4'd12);
        chk("cancelar", 32'(cancelar[0]), 32'd1);
        chk("cancel_reposo", 32'(ocupado[0]), 32'd0);
        step(1'b0, 4'd0, 1'b0, 1'b1);
        key(4'd11);
        chk("empty_enter", 32'(monto_stb[0]), 32'd0);
        key(4'd12);

        // Timeout eight cycles after the last key; a key on the terminal cycle wins
        step(1'b0, 4'd0, 1'b1, 1'b0);
        key(4'd5);
        idle(T - 1);
        chk("no_early_timeout", 32'(tiempo_agotado[0]), 32'd0);
        idle(1);
        chk("timeout", 32'(tiempo_agotado[0]), 32'd1);
        step(1'b0, 4'd0, 1'b1, 1'b0);
        key(4'd1);
        idle(T - 1);
        key(4'd2);
        chk("terminal_key_no_to", 32'(tiempo_agotado[0]), 32'd0);
        chk("terminal_key_stb", 32'(digito_stb[0]), 32'd1);
        key(4'd14);
        idle(T);

        // Asynchronous reset mid-amount
        step(1'b0, 4'd0, 1'b0, 1'b1);
        keys_num("31");
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        reset = 1'b1;

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            int r;
            bit tv;
            logic [3:0] k;
            r  = int'($urandom_range(0, 99));
            tv = $urandom_range(0, 9) < 6;
            k  = ($urandom_range(0, 9) < 7) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(10, 15));
            if ($urandom_range(0, 59) == 0) idle(int'($urandom_range(5, 12)));
            step(tv, k, r < 3, r >= 1 && r < 6);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/entrada_teclado.md
Name: entrada_teclado

Overview:
- Keypad front-end that drives the ATM controller's digit and amount inputs.
- Turns one-cycle keypad press events into the controller's PIN digit strobes (digito/digito_stb).
- Accumulates decimal amount keys into a 32-bit monto with a single monto_stb.
- Sits between the keypad decoder and the ATM controller; the controller requests PIN or amount entry through request pulses.

Parameters:
- PIN_DIGITS, 4, number of PIN digits forwarded per PIN request.
- MAX_DIGITS, 9, maximum accepted amount digits; further digits are ignored.
- TIMEOUT_CYCLES, 1000000, idle cycles in an entry state before abort.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- tecla  input  4  key code: 0-9 digit, 10 BORRAR, 11 ENTER, 12 CANCELAR, 13-15 unused.
- tecla_valida  input  1  one-cycle pulse; tecla valid this cycle.
- pedir_pin  input  1  one-cycle pulse; start PIN entry.
- pedir_monto  input  1  one-cycle pulse; start amount entry.
- digito  output  5  last PIN digit, zero-extended.
- digito_stb  output  1  one-cycle strobe per PIN digit.
- monto  output  32  confirmed amount, binary.
- monto_stb  output  1  one-cycle strobe when monto is confirmed.
- cancelar  output  1  one-cycle pulse on CANCELAR key.
- tiempo_agotado  output  1  one-cycle pulse on timeout.
- error_monto  output  1  sticky flag: an amount digit was rejected for overflow.
- ocupado  output  1  high when the state is not REPOSO.

Behaviour:
- Reset values:
  - All outputs 0, state REPOSO.
  - Accumulator, digit counter and timeout counter 0.
- All outputs are registered. Every response appears 1 cycle after the triggering input cycle.
- States are REPOSO, PIN and MONTO.
- REPOSO:
  - Keys are ignored.
  - pedir_pin goes to PIN; pedir_monto goes to MONTO. If both are high in the same cycle, pedir_pin wins.
  - Entering MONTO clears the accumulator, digit counter and error_monto.
  - Entering PIN clears the digit counter.
- pedir_* while in PIN or MONTO restarts the requested mode with the same clearing. A key in that same cycle is discarded.
- PIN state:
  - Digit key: digito <= {1'b0, tecla}, digito_stb high for exactly 1 cycle, counter +1.
  - After the PIN_DIGITS-th digit is strobed, go to REPOSO.
  - BORRAR and ENTER are ignored.
  - CANCELAR: cancelar pulse, go to REPOSO, no strobe.
- MONTO state:
  - Digit key: compute nuevo = acc*10 + tecla in 36 bits.
  - If nuevo > 32'hFFFFFFFF or the counter == MAX_DIGITS, the digit is discarded and acc is unchanged. Only the overflow case sets error_monto.
  - Otherwise acc <= nuevo[31:0] and the counter +1.
  - Leading zeros count as digits.
  - BORRAR: acc <= 0, counter <= 0. error_monto is unchanged.
  - ENTER with counter > 0: monto <= acc, monto_stb 1 cycle, go to REPOSO. ENTER with counter == 0 is ignored.
  - CANCELAR: cancelar pulse, go to REPOSO. monto is unchanged and there is no strobe.
- Output holding:
  - digito and monto hold their last values until the next strobe.
  - Strobes never assert in REPOSO except as the registered result of the final key.
- Timeout:
  - The counter clears on state entry and on every tecla_valida with code 0-12.
  - Codes 13-15 are fully ignored, including for the timeout counter.
  - When the counter reaches TIMEOUT_CYCLES-1 in PIN or MONTO: tiempo_agotado pulse, go to REPOSO.
  - A valid key in the terminal cycle wins: the key is processed and the counter clears.
- tecla_valida held high for several cycles counts as one key per cycle; the block does no debouncing.
- Asserting reset mid-entry immediately clears all state. A strobe pending for the next cycle is lost.

Test Plan:
- pedir_pin, then keys 1,2,3,4 -> four digito_stb pulses with digito 1,2,3,4, each 1 cycle after its key; ocupado falls after the 4th; a 5th key produces no strobe.
- pedir_monto, keys 2,5,0,0, ENTER -> monto_stb once with monto=2500; BORRAR after 2,5 then 7, ENTER -> monto=7.
- pedir_monto, keys 4,2,9,4,9,6,7,2,9,5 -> 9 digits accepted, 10th ignored; ENTER gives monto=429496729; error_monto stays 0.
- pedir_monto, 429496729 then 6 with MAX_DIGITS=10 -> digit rejected, error_monto=1, ENTER gives monto=429496729.
- pedir_pin, 1 digit, CANCELAR -> cancelar pulse, state REPOSO; pedir_monto, ENTER with no digits -> no strobe.
- TIMEOUT_CYCLES=8: pedir_pin, 1 digit, idle -> tiempo_agotado 8 cycles after the last key. Key on the terminal cycle -> no timeout. Reset low mid-amount -> all outputs 0 asynchronously.
